// File: rtl/ram_arbiter_2p_if.sv
// Requester-side bundle for the two-port RAM arbiter.
// Both request ports plus their grant/read-data returns.
interface ram_arbiter_2p_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 16
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
   );
endinterface

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter sharing one single-ported RAM between an
// instruction-fetch port (0) and a data port (1), one access at a time.
module ram_arbiter_2p #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_arbiter_2p_if.slave   bus,
   output logic              busy,
   output logic              ram_read_en,
   output logic              ram_write_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

   state_t            state, state_nx;
   logic              sel_q, sel_d;
   logic              we_q, we_d;
   logic              last_gnt, last_gnt_d;
   logic              pick1;
   logic              gnt0_d, gnt1_d, rvalid0_d, rvalid1_d;
   logic              ren_d, wen_d, busy_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] din_d;

   // Port 1 wins when alone, or on contention when port 0 was served last.
   assign pick1 = bus.req1 & (~bus.req0 | ~last_gnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.req0 | bus.req1) state_nx = ISSUE;
         ISSUE:   state_nx = we_q ? IDLE : RDATA;
         RDATA:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Next values for the registered outputs, so they line up with the state they belong to.
   always_comb begin
      sel_d      = sel_q;
      we_d       = we_q;
      last_gnt_d = last_gnt;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      rvalid0_d  = 1'b0;
      rvalid1_d  = 1'b0;
      ren_d      = 1'b0;
      wen_d      = 1'b0;
      addr_d     = ram_addr;
      din_d      = ram_din;
      busy_d     = (state_nx != IDLE);
      case (state)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               sel_d  = pick1;
               we_d   = pick1 ? bus.we1    : bus.we0;
               addr_d = pick1 ? bus.addr1  : bus.addr0;
               din_d  = pick1 ? bus.wdata1 : bus.wdata0;
               gnt0_d = ~pick1;
               gnt1_d = pick1;
               wen_d  = we_d;
               ren_d  = ~we_d;
            end
         end
         ISSUE: begin
            last_gnt_d = sel_q;
            rvalid0_d  = ~we_q & ~sel_q;
            rvalid1_d  = ~we_q & sel_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q        <= 1'b0;
         we_q         <= 1'b0;
         last_gnt     <= 1'b1;
         bus.gnt0     <= 1'b0;
         bus.gnt1     <= 1'b0;
         bus.rvalid0  <= 1'b0;
         bus.rvalid1  <= 1'b0;
         ram_read_en  <= 1'b0;
         ram_write_en <= 1'b0;
         ram_addr     <= '0;
         ram_din      <= '0;
         busy         <= 1'b0;
      end else begin
         sel_q        <= sel_d;
         we_q         <= we_d;
         last_gnt     <= last_gnt_d;
         bus.gnt0     <= gnt0_d;
         bus.gnt1     <= gnt1_d;
         bus.rvalid0  <= rvalid0_d;
         bus.rvalid1  <= rvalid1_d;
         ram_read_en  <= ren_d;
         ram_write_en <= wen_d;
         ram_addr     <= addr_d;
         ram_din      <= din_d;
         busy         <= busy_d;
      end
   end

   // RAM output is already registered; steer it to the port whose rvalid is up.
   assign bus.rdata0 = bus.rvalid0 ? ram_dout : '0;
   assign bus.rdata1 = bus.rvalid1 ? ram_dout : '0;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural 16x1024 RAM behind it.
module tb_ram_arbiter_2p;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              busy, ram_read_en, ram_write_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   int n_vec = 0;
   int n_err = 0;

   ram_arbiter_2p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_arbiter_2p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .busy         (busy),
      .ram_read_en  (ram_read_en),
      .ram_write_en (ram_write_en),
      .ram_addr     (ram_addr),
      .ram_din      (ram_din),
      .ram_dout     (ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_write_en) mem[ram_addr] <= ram_din;
      if (ram_read_en)  ram_dout <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " gnt0"},    32'(bus.gnt0), 0);
      check({tag, " gnt1"},    32'(bus.gnt1), 0);
      check({tag, " rvalid0"}, 32'(bus.rvalid0), 0);
      check({tag, " rvalid1"}, 32'(bus.rvalid1), 0);
      check({tag, " ren"},     32'(ram_read_en), 0);
      check({tag, " wen"},     32'(ram_write_en), 0);
      check({tag, " busy"},    32'(busy), 0);
   endtask

   logic [7:0] exp_g0, exp_g1;

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
      ram_dout   = '0;
      rst_n      = 1'b0;
      bus.req0   = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0  = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      #2;
      check_idle_outputs("reset");
      check("reset addr",   32'(ram_addr), 0);
      check("reset din",    32'(ram_din), 0);
      check("reset rdata0", 32'(bus.rdata0), 0);
      check("reset rdata1", 32'(bus.rdata1), 0);
      tick(); tick();
      rst_n = 1'b1;

      // Port 0 write 0xBEEF @0x005, then read it back
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 10'h005; bus.wdata0 = 16'hBEEF;
      tick();
      check("w gnt0",  32'(bus.gnt0), 1);
      check("w gnt1",  32'(bus.gnt1), 0);
      check("w wen",   32'(ram_write_en), 1);
      check("w ren",   32'(ram_read_en), 0);
      check("w addr",  32'(ram_addr), 32'h005);
      check("w din",   32'(ram_din), 32'hBEEF);
      check("w busy",  32'(busy), 1);
      bus.req0 = 0;
      tick();
      check_idle_outputs("w done");
      check("w addr hold", 32'(ram_addr), 32'h005);
      bus.req0 = 1; bus.we0 = 0;
      tick();
      check("r gnt0", 32'(bus.gnt0), 1);
      check("r ren",  32'(ram_read_en), 1);
      check("r wen",  32'(ram_write_en), 0);
      bus.req0 = 0;
      tick();
      check("r rvalid0", 32'(bus.rvalid0), 1);
      check("r rvalid1", 32'(bus.rvalid1), 0);
      check("r rdata0",  32'(bus.rdata0), 32'hBEEF);
      check("r rdata1",  32'(bus.rdata1), 0);
      check("r busy",    32'(busy), 1);
      check("r gnt0 off", 32'(bus.gnt0), 0);
      tick();
      check_idle_outputs("r done");
      check("r rdata0 off", 32'(bus.rdata0), 0);

      // Contended reads in the first IDLE after reset
      rst_n = 1'b0; #1; rst_n = 1'b1;
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h000;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'h005;
      tick();
      check("c gnt0", 32'(bus.gnt0), 1);
      check("c gnt1", 32'(bus.gnt1), 0);
      bus.req0 = 0;
      tick();
      check("c rvalid0",  32'(bus.rvalid0), 1);
      check("c rvalid1",  32'(bus.rvalid1), 0);
      check("c rdata1 a", 32'(bus.rdata1), 0);
      tick();
      check("c idle gnt1", 32'(bus.gnt1), 0);
      tick();
      check("c gnt1 late", 32'(bus.gnt1), 1);
      check("c gnt0 late", 32'(bus.gnt0), 0);
      bus.req1 = 0;
      tick();
      check("c rvalid1 b", 32'(bus.rvalid1), 1);
      check("c rvalid0 b", 32'(bus.rvalid0), 0);
      check("c rdata1 b",  32'(bus.rdata1), 32'hBEEF);
      check("c rdata0 b",  32'(bus.rdata0), 0);
      tick();

      // Continuous contended writes to 0x3FF alternate 0,1,0,1
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 10'h3FF; bus.wdata0 = 16'h1111;
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10'h3FF; bus.wdata1 = 16'h2222;
      exp_g0 = 8'b0001_0001;
      exp_g1 = 8'b0100_0100;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("alt gnt0 %0d", i), 32'(bus.gnt0), 32'(exp_g0[i]));
         check($sformatf("alt gnt1 %0d", i), 32'(bus.gnt1), 32'(exp_g1[i]));
         check($sformatf("alt excl %0d", i), 32'(ram_read_en & ram_write_en), 0);
         if (exp_g1[i]) check($sformatf("alt din %0d", i), 32'(ram_din), 32'h2222);
         if (exp_g0[i]) check($sformatf("alt din %0d", i), 32'(ram_din), 32'h1111);
      end
      bus.req0 = 0; bus.req1 = 0;
      tick();

      // Port 1 write 0xA5A5 @0x000; port 0 read of 0x000 arrives during ISSUE
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10'h000; bus.wdata1 = 16'hA5A5;
      tick();
      check("raw gnt1", 32'(bus.gnt1), 1);
      check("raw wen",  32'(ram_write_en), 1);
      bus.req1 = 0;
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h000;
      tick();
      check("raw wait gnt0", 32'(bus.gnt0), 0);
      tick();
      check("raw gnt0", 32'(bus.gnt0), 1);
      check("raw addr", 32'(ram_addr), 0);
      bus.req0 = 0;
      tick();
      check("raw rvalid0", 32'(bus.rvalid0), 1);
      check("raw rdata0",  32'(bus.rdata0), 32'hA5A5);
      tick();

      // Reset during ISSUE of a write: write must be dropped
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 10'h010; bus.wdata0 = 16'h1234;
      tick();
      check("rst pre gnt0", 32'(bus.gnt0), 1);
      bus.req0 = 0;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("rst mid");
      check("rst mid addr", 32'(ram_addr), 0);
      check("rst mid din",  32'(ram_din), 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rst post busy", 32'(busy), 0);
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h010;
      tick();
      check("rst rd gnt0", 32'(bus.gnt0), 1);
      bus.req0 = 0;
      tick();
      check("rst rd rvalid0", 32'(bus.rvalid0), 1);
      check("rst rd rdata0",  32'(bus.rdata0), 0);
      tick();
      check("rst end busy", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ram_arbiter_2p.md
# ram_arbiter_2p

Two-port arbiter sharing the single-ported 16x1024 CPU RAM between requester 0 (instruction fetch) and requester 1 (data load/store). It takes one access at a time from one requester and drives the RAM read_en/write_en/addr/din strobes. It returns read data with a valid pulse. Contention is resolved round-robin, so neither port can starve the other.

## Interface
- ADDR_W, 10, RAM address width (1024 words)
- DATA_W, 16, RAM data width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request; held high with fields stable until the matching gnt is seen
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: this port's access is being issued to RAM this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata for this port is valid
- rdata0 / rdata1  out  DATA_W  ram_dout when the matching rvalid is high, else 0
- busy  out  1  high in any state other than IDLE
- ram_read_en  out  1  to RAM read_en
- ram_write_en  out  1  to RAM write_en
- ram_addr  out  ADDR_W  to RAM addr
- ram_din  out  DATA_W  to RAM din
- ram_dout  in  DATA_W  from RAM dout, registered in RAM, valid the cycle after ram_read_en

## Operation
- FSM has three states: IDLE, ISSUE, RDATA.
- IDLE: sample req0/req1.
  - Neither high: stay in IDLE.
  - One high: select it.
  - Both high: select the port not in last_gnt.
  - On selection, register sel, we, addr and wdata, then go to ISSUE.
- ISSUE (one cycle):
  - Drive ram_addr and ram_din from the registers.
  - Drive ram_write_en = we and ram_read_en = ~we. The two are never high together.
  - Pulse gnt[sel] and update last_gnt <= sel.
  - Next state: RDATA if read, IDLE if write.
- RDATA (one cycle):
  - Pulse rvalid[sel].
  - rdata[sel] = ram_dout; the other port's rdata is 0.
  - Next state: IDLE.
- Requester rule: deassert req, or present the next request, on the edge at which gnt is high. The arbiter never re-samples a port during ISSUE or RDATA.
- All ram_* strobes and gnt are registered outputs, 0 outside ISSUE. ram_addr and ram_din hold their last value.
- last_gnt resets to 1, so port 0 wins the first contended cycle.
- Requests arriving in ISSUE or RDATA wait. The arbiter samples them in the next IDLE.

## Timing
- Reset (async, immediate):
  - State = IDLE, last_gnt = 1.
  - gnt0, gnt1, rvalid0, rvalid1, busy, ram_read_en and ram_write_en = 0.
  - ram_addr, ram_din, rdata0 and rdata1 = 0.
- Reset asserted mid-access: the access is abandoned with no gnt or rvalid completion. If ISSUE had not yet reached its edge, the RAM write does not happen.
- Write, req seen in IDLE at cycle N:
  - Cycle N+1: ISSUE, gnt and ram_write_en high.
  - The RAM stores on the edge ending N+1.
  - Cycle N+2: IDLE. Occupancy is 2 cycles.
- Read, req seen at cycle N:
  - Cycle N+1: ISSUE, gnt and ram_read_en high.
  - Cycle N+2: RDATA, rvalid high with ram_dout. Occupancy is 3 cycles.
- Back-to-back: a requester that re-requests at the gnt edge is sampled in the following IDLE.
- Under continuous contention, grants alternate 0,1,0,1.
- addr wrap is not applicable: a full ADDR_W-bit address is passed through unmodified, and addresses 0 and 1023 are legal.

## Test plan
- Reset, then port 0 writes 0xBEEF to addr 0x005 and reads addr 0x005 -> gnt0 at +1 on each access. ram_write_en is high for exactly one cycle with ram_addr = 0x005. rvalid0 comes 2 cycles after the read request with rdata0 = 0xBEEF, and rdata1 = 0.
- req0 and req1 both reads, asserted together in the first IDLE after reset -> port 0 is granted first, port 1 three cycles later, and each rvalid goes only to its own port.
- Both ports hold req continuously with writes of 0x1111 and 0x2222 to addr 0x3FF -> grants alternate 0,1,0,1 every 2 cycles. ram_read_en and ram_write_en are never high together.
- Port 1 writes 0xA5A5 at addr 0x000 while port 0 requests a read of addr 0x000 in the ISSUE cycle -> the read is granted afterwards and returns 0xA5A5.
- rst_n is pulled low during ISSUE of a write of 0x1234 to addr 0x010 -> all outputs are 0 immediately. After release, a read of 0x010 does not return 0x1234 if the reset hit before the edge. busy = 0 after reset.
